// File: rtl/traffic_ctrl_param.sv
// Two-road traffic-light controller with on-demand walk phase, tick-enabled timing
// and a night flashing mode. Lamps are a Moore decode of the registered state.
module traffic_ctrl_param #(
    parameter int G_LEN      = 40,
    parameter int Y_LEN      = 5,
    parameter int GAP_LEN    = 2,
    parameter int WG_LEN     = 26,
    parameter int BLK_LEN    = 6,
    parameter int CNT_W      = 8,
    parameter bit PED_ALWAYS = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic       Road1_G,
    output logic       Road1_Y,
    output logic       Road1_R,
    output logic       Road2_G,
    output logic       Road2_Y,
    output logic       Road2_R,
    output logic       Walk_G,
    output logic       Walk_R,
    output logic [3:0] phase,
    output logic       ped_wait
);

    typedef enum logic [3:0] {
        R1_G     = 4'd0,
        R1_Y     = 4'd1,
        GAP1     = 4'd2,
        R2_G     = 4'd3,
        R2_Y     = 4'd4,
        GAP2     = 4'd5,
        WALK_G   = 4'd6,
        WALK_BLK = 4'd7,
        GAP3     = 4'd8,
        NIGHT    = 4'd9
    } state_t;

    localparam int MAX_LEN = 2 ** CNT_W;

    if (G_LEN < 1 || G_LEN > MAX_LEN || Y_LEN < 1 || Y_LEN > MAX_LEN ||
        GAP_LEN < 1 || GAP_LEN > MAX_LEN || WG_LEN < 1 || WG_LEN > MAX_LEN ||
        BLK_LEN < 1 || BLK_LEN > MAX_LEN) begin : g_bad_len
        $error("traffic_ctrl_param: every *_LEN must be in 1..2**CNT_W");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic             ped_wait_q, ped_wait_d;
    logic             advance;
    logic             entering;

    function automatic logic [CNT_W-1:0] load_val(input state_t s);
        logic [CNT_W-1:0] v;
        case (s)
            R1_G, R2_G:       v = CNT_W'(G_LEN - 1);
            R1_Y, R2_Y:       v = CNT_W'(Y_LEN - 1);
            GAP1, GAP2, GAP3: v = CNT_W'(GAP_LEN - 1);
            WALK_G:           v = CNT_W'(WG_LEN - 1);
            WALK_BLK:         v = CNT_W'(BLK_LEN - 1);
            default:          v = '0;
        endcase
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= R1_G;
            cnt_q      <= CNT_W'(G_LEN - 1);
            blink_q    <= 1'b0;
            ped_wait_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blink_q    <= blink_d;
            ped_wait_q <= ped_wait_d;
        end
    end

    // A request arriving on the GAP2 exit cycle still wins the walk phase.
    always_comb begin
        state_d = state_q;
        advance = tick && (cnt_q == '0);
        case (state_q)
            R1_G:     if (advance) state_d = R1_Y;
            R1_Y:     if (advance) state_d = GAP1;
            GAP1:     if (advance) state_d = night_mode ? NIGHT : R2_G;
            R2_G:     if (advance) state_d = R2_Y;
            R2_Y:     if (advance) state_d = GAP2;
            GAP2: begin
                if (advance) begin
                    if (night_mode)
                        state_d = NIGHT;
                    else if (ped_wait_q || ped_req || PED_ALWAYS)
                        state_d = WALK_G;
                    else
                        state_d = R1_G;
                end
            end
            WALK_G:   if (advance) state_d = WALK_BLK;
            WALK_BLK: if (advance) state_d = GAP3;
            GAP3:     if (advance) state_d = night_mode ? NIGHT : R1_G;
            NIGHT:    if (tick && !night_mode) state_d = GAP3;
            default:  state_d = R1_G;
        endcase
    end

    always_comb begin
        entering   = (state_d != state_q);
        cnt_d      = cnt_q;
        blink_d    = blink_q;
        ped_wait_d = ped_wait_q;

        if (entering)
            cnt_d = load_val(state_d);
        else if (tick && state_q != NIGHT)
            cnt_d = cnt_q - 1'b1;

        if (entering && state_d == WALK_BLK)
            blink_d = 1'b0;
        else if (entering && state_d == NIGHT)
            blink_d = 1'b1;
        else if (!entering && tick && (state_q == WALK_BLK || state_q == NIGHT))
            blink_d = ~blink_q;

        if (entering && (state_d == WALK_G || state_d == NIGHT))
            ped_wait_d = 1'b0;
        else if (ped_req && state_q != WALK_G && state_q != NIGHT)
            ped_wait_d = 1'b1;
    end

    // In night mode road 2 flashes red while road 1 flashes yellow.
    always_comb begin
        Road1_G = 1'b0;
        Road1_Y = 1'b0;
        Road1_R = 1'b0;
        Road2_G = 1'b0;
        Road2_Y = 1'b0;
        Road2_R = 1'b0;
        Walk_G  = 1'b0;
        Walk_R  = 1'b0;
        case (state_q)
            R1_G: begin
                Road1_G = 1'b1;
                Road2_R = 1'b1;
                Walk_R  = 1'b1;
            end
            R1_Y: begin
                Road1_Y = 1'b1;
                Road2_R = 1'b1;
                Walk_R  = 1'b1;
            end
            R2_G: begin
                Road1_R = 1'b1;
                Road2_G = 1'b1;
                Walk_R  = 1'b1;
            end
            R2_Y: begin
                Road1_R = 1'b1;
                Road2_Y = 1'b1;
                Walk_R  = 1'b1;
            end
            WALK_G: begin
                Road1_R = 1'b1;
                Road2_R = 1'b1;
                Walk_G  = 1'b1;
            end
            WALK_BLK: begin
                Road1_R = 1'b1;
                Road2_R = 1'b1;
                Walk_G  = blink_q;
            end
            NIGHT: begin
                Road1_Y = blink_q;
                Road2_R = blink_q;
                Walk_R  = 1'b1;
            end
            default: begin
                Road1_R = 1'b1;
                Road2_R = 1'b1;
                Walk_R  = 1'b1;
            end
        endcase
    end

    assign phase    = state_q;
    assign ped_wait = ped_wait_q;

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Self-checking bench for traffic_ctrl_param: a phase/elapsed-tick model checked every
// cycle, plus directed scenarios with hand-computed durations and lamp values.
module tb_traffic_ctrl_param;

    localparam int G_LEN = 40, Y_LEN = 5, GAP_LEN = 2, WG_LEN = 26, BLK_LEN = 6;
    localparam int LIMIT = 2000;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick = 1'b1;
    logic       ped_req = 1'b0;
    logic       night_mode = 1'b0;
    logic       Road1_G, Road1_Y, Road1_R, Road2_G, Road2_Y, Road2_R, Walk_G, Walk_R;
    logic [3:0] phase;
    logic       ped_wait;

    int vectors = 0;
    int miscompares = 0;
    bit slow_tick = 1'b0;
    int tdiv = 0;

    traffic_ctrl_param #(
        .G_LEN(G_LEN), .Y_LEN(Y_LEN), .GAP_LEN(GAP_LEN), .WG_LEN(WG_LEN),
        .BLK_LEN(BLK_LEN), .CNT_W(8), .PED_ALWAYS(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .ped_req(ped_req), .night_mode(night_mode),
        .Road1_G(Road1_G), .Road1_Y(Road1_Y), .Road1_R(Road1_R),
        .Road2_G(Road2_G), .Road2_Y(Road2_Y), .Road2_R(Road2_R),
        .Walk_G(Walk_G), .Walk_R(Walk_R), .phase(phase), .ped_wait(ped_wait)
    );

    always #5 clk = ~clk;

    wire [7:0] act_lamps = {Road1_G, Road1_Y, Road1_R, Road2_G, Road2_Y, Road2_R, Walk_G, Walk_R};

    // Tick source: tied high, or one tick every fourth clock.
    always @(negedge clk) begin
        tdiv = (tdiv + 1) % 4;
        tick = slow_tick ? (tdiv == 0) : 1'b1;
    end

    // Reference model: phase index, ticks spent in it, pending request, flash level.
    int m_phase = 0, m_elapsed = 0;
    bit m_wait = 1'b0, m_flash = 1'b0;

    function automatic int phase_len(input int p);
        case (p)
            0, 3:    return G_LEN;
            1, 4:    return Y_LEN;
            6:       return WG_LEN;
            7:       return BLK_LEN;
            default: return GAP_LEN;
        endcase
    endfunction

    function automatic logic [7:0] exp_lamps(input int p, input bit f);
        case (p)
            0:       return 8'b100_001_01;
            1:       return 8'b010_001_01;
            3:       return 8'b001_100_01;
            4:       return 8'b001_010_01;
            6:       return 8'b001_001_10;
            7:       return {6'b001_001, f, 1'b0};
            9:       return {1'b0, f, 1'b0, 2'b00, f, 2'b01};
            default: return 8'b001_001_01;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        int nxt;
        if (!rst) begin
            m_phase = 0; m_elapsed = 0; m_wait = 1'b0; m_flash = 1'b0;
        end else begin
            nxt = m_phase;
            if (tick) begin
                if (m_phase == 9) begin
                    if (!night_mode) nxt = 8;
                end else if (m_elapsed == phase_len(m_phase) - 1) begin
                    case (m_phase)
                        2:       nxt = night_mode ? 9 : 3;
                        5:       nxt = night_mode ? 9 : ((m_wait || ped_req) ? 6 : 0);
                        8:       nxt = night_mode ? 9 : 0;
                        default: nxt = m_phase + 1;
                    endcase
                end
            end
            if (nxt != m_phase && (nxt == 6 || nxt == 9)) m_wait = 1'b0;
            else if (ped_req && m_phase != 6 && m_phase != 9) m_wait = 1'b1;
            if (nxt != m_phase) begin
                m_elapsed = 0;
                if (nxt == 7) m_flash = 1'b0;
                if (nxt == 9) m_flash = 1'b1;
            end else if (tick) begin
                m_elapsed++;
                if (m_phase == 7 || m_phase == 9) m_flash = ~m_flash;
            end
            m_phase = nxt;
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        checkOutput("lamps", int'(act_lamps), int'(exp_lamps(m_phase, m_flash)));
        checkOutput("phase", int'(phase), m_phase);
        checkOutput("ped_wait", int'(ped_wait), int'(m_wait));
    end

    task automatic timeout(input string what);
        vectors++;
        miscompares++;
        $display("[TB] FAIL timeout waiting for %s: got %0d cycles, expected fewer", what, LIMIT);
    endtask

    task automatic wait_rise(output int n);
        logic prev;
        n = 0;
        prev = Road1_G;
        while (1) begin
            @(negedge clk);
            n++;
            if (!prev && Road1_G) break;
            prev = Road1_G;
            if (n >= LIMIT) begin timeout("Road1_G rise"); break; end
        end
    endtask

    task automatic measure_high(output int n);
        n = 0;
        while (Road1_G && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_phase(input int p);
        int n = 0;
        while (int'(phase) != p && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) timeout("phase");
    endtask

    task automatic applyStimulus(input bit req, input bit night);
        @(negedge clk);
        ped_req    = req;
        night_mode = night;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset lamps", int'(act_lamps), int'(8'b100_001_01));
        checkOutput("reset phase", int'(phase), 0);
        rst = 1'b1;

        // Plain cycle, no requests.
        measure_high(n);
        checkOutput("first R1_G length", n, 40);
        wait_rise(n);
        checkOutput("first rise", n, 54);
        wait_rise(n);
        checkOutput("period no walk", n, 94);
        checkOutput("no request", int'(ped_wait), 0);

        // Single pulse during R1_G.
        repeat (3) @(negedge clk);
        applyStimulus(1'b0, 1'b0);
        ped_req = 1'b1;
        applyStimulus(1'b0, 1'b0);
        checkOutput("pulse latched", int'(ped_wait), 1);
        n = 0;
        while (!Walk_G && n < LIMIT) begin @(negedge clk); n++; end
        if (n >= LIMIT) timeout("Walk_G");
        checkOutput("cleared on walk", int'(ped_wait), 0);
        n = 0;
        while (!Road1_G && n < LIMIT) begin @(negedge clk); n++; end
        checkOutput("walk to R1_G", n, 34);

        // Request held: every cycle includes the walk phase.
        ped_req = 1'b1;
        wait_rise(n);
        checkOutput("period with walk", n, 128);
        ped_req = 1'b0;

        // One tick in four stretches every phase by four.
        slow_tick = 1'b1;
        wait_rise(n);
        measure_high(n);
        checkOutput("slow R1_G length", n, 160);
        slow_tick = 1'b0;

        // Night mode requested during R2_G.
        wait_phase(3);
        night_mode = 1'b1;
        wait_phase(9);
        checkOutput("night Y1 #0", int'(Road1_Y), 1);
        checkOutput("night R2 #0", int'(Road2_R), 1);
        checkOutput("night Walk_R", int'(Walk_R), 1);
        @(negedge clk);
        checkOutput("night Y1 #1", int'(Road1_Y), 0);
        checkOutput("night R2 #1", int'(Road2_R), 0);
        @(negedge clk);
        checkOutput("night Y1 #2", int'(Road1_Y), 1);
        night_mode = 1'b0;
        @(negedge clk);
        n = 0;
        while (int'(phase) == 8 && n < LIMIT) begin n++; @(negedge clk); end
        checkOutput("GAP3 after night", n, 2);
        checkOutput("R1_G after night", int'(phase), 0);

        // Reset in the middle of the blink phase.
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        wait_phase(7);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checkOutput("async reset lamps", int'(act_lamps), int'(8'b100_001_01));
        checkOutput("async reset phase", int'(phase), 0);
        checkOutput("async reset wait", int'(ped_wait), 0);
        @(negedge clk);
        rst = 1'b1;
        measure_high(n);
        checkOutput("R1_G after reset", n, 40);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
